// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes, widths and the
// decode helper that classifies an opcode's register usage.
package cpu_pkg;

    localparam int NREGS   = 16;
    localparam int XLEN    = 32;
    localparam int REG_W   = 4;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 16;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 20;
    localparam int RS2_LSB = 16;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_ALU_RR = 4'h1;
    localparam logic [OP_W-1:0] OP_ALU_RI = 4'h2;
    localparam logic [OP_W-1:0] OP_LOAD   = 4'h3;
    localparam logic [OP_W-1:0] OP_STORE  = 4'h4;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'h5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEC   = 2'd1,
        RD    = 2'd2,
        ISSUE = 2'd3
    } id_state_e;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes;
    } op_class_t;

    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ALU_RR: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.writes  = 1'b1;
            end
            OP_ALU_RI, OP_LOAD: begin
                c.use_rs1 = 1'b1;
                c.writes  = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
            end
            OP_NOP:  c = '0;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at operand
// read, cleared by writeback or by flushing the instruction that set it.
module id_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic             flush_clr_en_i,
    input  logic [REG_W-1:0] flush_clr_idx_i,
    input  logic             use_rs1_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic             use_rs2_i,
    input  logic [REG_W-1:0] rs2_i,
    output logic             hazard_o
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                // r0 is never written, so its bit can never be pending
                assign sb_d[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_en_i && (set_idx_i == REG_W'(gi));
                assign clr_hit = (clr_en_i && (clr_idx_i == REG_W'(gi))) ||
                                 (flush_clr_en_i && (flush_clr_idx_i == REG_W'(gi)));
                // set beats any same-cycle clear of the same register
                assign sb_d[gi] = set_hit | (sb_q[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Lookups use the registered bits only: a writeback is seen next cycle.
    assign hazard_o = (use_rs1_i && (rs1_i != '0) && sb_q[rs1_i]) ||
                      (use_rs2_i && (rs2_i != '0) && sb_q[rs2_i]);

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: accepts an instruction, waits out RAW hazards, reads the
// register file and hands a decoded bundle to execute.
module id_issue_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic            rf_rd_en,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [3:0]      wb_rd,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_op,
    output logic [3:0]      ex_rd,
    output logic            ex_we,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc
);

    id_state_e       state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [3:0]      ex_op_q, ex_op_d;
    logic [3:0]      ex_rd_q, ex_rd_d;
    logic            ex_we_q, ex_we_d;
    logic [XLEN-1:0] ex_a_q, ex_a_d;
    logic [XLEN-1:0] ex_b_q, ex_b_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;

    logic [OP_W-1:0]  f_op;
    logic [REG_W-1:0] f_rd, f_rs1, f_rs2;
    logic [IMM_W-1:0] f_imm;
    op_class_t        f_cls;
    logic             f_writes;

    logic hazard;
    logic sb_set;
    logic sb_fclr;
    logic if_ready_c;
    logic rf_rd_en_c;

    assign f_op     = instr_q[OP_LSB +: OP_W];
    assign f_rd     = instr_q[RD_LSB +: REG_W];
    assign f_rs1    = instr_q[RS1_LSB +: REG_W];
    assign f_rs2    = instr_q[RS2_LSB +: REG_W];
    assign f_imm    = instr_q[IMM_LSB +: IMM_W];
    assign f_cls    = op_class(f_op);
    assign f_writes = f_cls.writes && (f_rd != '0);

    id_scoreboard u_sb (
        .clk             (clk),
        .reset           (reset),
        .set_en_i        (sb_set),
        .set_idx_i       (f_rd),
        .clr_en_i        (wb_valid),
        .clr_idx_i       (wb_rd),
        .flush_clr_en_i  (sb_fclr),
        .flush_clr_idx_i (f_rd),
        .use_rs1_i       (f_cls.use_rs1),
        .rs1_i           (f_rs1),
        .use_rs2_i       (f_cls.use_rs2),
        .rs2_i           (f_rs2),
        .hazard_o        (hazard)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_pc_d    = ex_pc_q;
        if_ready_c = 1'b0;
        rf_rd_en_c = 1'b0;
        sb_set     = 1'b0;
        sb_fclr    = 1'b0;

        case (state_q)
            IDLE: begin
                if_ready_c = 1'b1;
                if (if_valid) begin
                    instr_d = if_instr;
                    pc_d    = if_pc;
                    state_d = DEC;
                end
            end
            DEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!hazard) begin
                    rf_rd_en_c = 1'b1;
                    state_d    = RD;
                end
            end
            RD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    ex_op_d  = f_op;
                    ex_rd_d  = f_rd;
                    ex_we_d  = f_writes;
                    ex_a_d   = (f_cls.use_rs1 && (f_rs1 != '0)) ? rf_rdata1 : '0;
                    ex_b_d   = (f_cls.use_rs2 && (f_rs2 != '0)) ? rf_rdata2 : '0;
                    ex_imm_d = {{(XLEN-IMM_W){f_imm[IMM_W-1]}}, f_imm};
                    ex_pc_d  = pc_q;
                    sb_set   = f_writes;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    // undo the pending-write mark this instruction placed in RD
                    sb_fclr = ex_we_q;
                    state_d = IDLE;
                end else if (ex_ready) begin
                    if_ready_c = 1'b1;
                    if (if_valid) begin
                        instr_d = if_instr;
                        pc_d    = if_pc;
                        state_d = DEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            ex_op_q  <= '0;
            ex_rd_q  <= '0;
            ex_we_q  <= 1'b0;
            ex_a_q   <= '0;
            ex_b_q   <= '0;
            ex_imm_q <= '0;
            ex_pc_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            ex_op_q  <= ex_op_d;
            ex_rd_q  <= ex_rd_d;
            ex_we_q  <= ex_we_d;
            ex_a_q   <= ex_a_d;
            ex_b_q   <= ex_b_d;
            ex_imm_q <= ex_imm_d;
            ex_pc_q  <= ex_pc_d;
        end
    end

    // Handshake and read-port outputs are held quiet while reset is asserted.
    assign if_ready  = if_ready_c & ~reset;
    assign rf_rd_en  = rf_rd_en_c & ~reset;
    assign rf_raddr1 = reset ? 5'd0 : {1'b0, f_rs1};
    assign rf_raddr2 = reset ? 5'd0 : {1'b0, f_rs2};
    assign ex_valid  = (state_q == ISSUE) & ~reset;
    assign ex_op     = ex_op_q;
    assign ex_rd     = ex_rd_q;
    assign ex_we     = ex_we_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_imm    = ex_imm_q;
    assign ex_pc     = ex_pc_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage with a registered register-file model.
module tb_id_issue_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        rf_rd_en;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] rf_mem [32];

    id_issue_stage dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rd_en  (rf_rd_en),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_rd     (ex_rd),
        .ex_we     (ex_we),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_imm    (ex_imm),
        .ex_pc     (ex_pc)
    );

    always #5 clk = ~clk;

    // Registered-read register file: data appears the cycle after rf_rd_en.
    always @(posedge clk) begin
        if (reset) begin
            rf_rdata1 <= '0;
            rf_rdata2 <= '0;
        end else if (rf_rd_en) begin
            rf_rdata1 <= rf_mem[rf_raddr1];
            rf_rdata2 <= rf_mem[rf_raddr2];
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_clear(input logic [3:0] idx);
        wb_valid = 1'b1;
        wb_rd    = idx;
        tick();
        wb_valid = 1'b0;
    endtask

    // Push one instruction through with ex_ready high; ends after the handshake.
    task automatic issue_one(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        n = 0;
        while (!if_ready && n < 50) begin
            tick();
            n++;
        end
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        tick();
        if_valid = 1'b0;
        n = 0;
        while (!(ex_valid && ex_ready) && n < 50) begin
            tick();
            n++;
        end
        check_vec("issue_hs", 32'(ex_valid & ex_ready), 32'd1);
        tick();
    endtask

    function automatic logic [31:0] sb_now();
        return 32'(dut.u_sb.sb_q);
    endfunction

    function automatic logic [31:0] st_now();
        return 32'(dut.state_q);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(32'h11 * i);
        rf_mem[0] = 32'hDEADBEEF;
        reset    = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;

        // reset state
        tick();
        check_vec("rst_if_ready", 32'(if_ready), 32'd0);
        check_vec("rst_state", st_now(), 32'(IDLE));
        check_vec("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_vec("rst_rd_en", 32'(rf_rd_en), 32'd0);
        check_vec("rst_raddr1", 32'(rf_raddr1), 32'd0);
        check_vec("rst_ex_a", ex_a, 32'd0);
        check_vec("rst_ex_we", 32'(ex_we), 32'd0);
        check_vec("rst_sb", sb_now(), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_vec("post_rst_if_ready", 32'(if_ready), 32'd1);

        // ALU_RR r3 = r1 + r2
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RR, 4'd3, 4'd1, 4'd2, 16'h8001);
        if_pc    = 32'h100;
        tick();
        if_valid = 1'b0;
        check_vec("rr_dec_rd_en", 32'(rf_rd_en), 32'd1);
        check_vec("rr_raddr1", 32'(rf_raddr1), 32'd1);
        check_vec("rr_raddr2", 32'(rf_raddr2), 32'd2);
        check_vec("rr_dec_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        check_vec("rr_rd_rd_en", 32'(rf_rd_en), 32'd0);
        check_vec("rr_rd_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        check_vec("rr_ex_valid", 32'(ex_valid), 32'd1);
        check_vec("rr_ex_a", ex_a, 32'h11);
        check_vec("rr_ex_b", ex_b, 32'h22);
        check_vec("rr_ex_rd", 32'(ex_rd), 32'd3);
        check_vec("rr_ex_we", 32'(ex_we), 32'd1);
        check_vec("rr_ex_op", 32'(ex_op), 32'd1);
        check_vec("rr_ex_imm", ex_imm, 32'hFFFF8001);
        check_vec("rr_ex_pc", ex_pc, 32'h100);
        check_vec("rr_sb", sb_now(), 32'h0008);
        tick();
        check_vec("rr_done_valid", 32'(ex_valid), 32'd0);
        check_vec("rr_done_state", st_now(), 32'(IDLE));
        wb_clear(4'd3);
        check_vec("rr_wb_sb", sb_now(), 32'd0);

        // RAW hazard: LOAD r5, then ALU_RI r6 = r5 + 0x10
        issue_one(mk(OP_LOAD, 4'd5, 4'd1, 4'd0, 16'h0004), 32'h104);
        check_vec("raw_sb_set", sb_now(), 32'h0020);
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd6, 4'd5, 4'd7, 16'h0010);
        if_pc    = 32'h108;
        tick();
        if_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec("raw_stall_rd_en", 32'(rf_rd_en), 32'd0);
            check_vec("raw_stall_state", st_now(), 32'(DEC));
            tick();
        end
        wb_valid = 1'b1;
        wb_rd    = 4'd5;
        #1;
        check_vec("raw_wb_no_bypass", 32'(rf_rd_en), 32'd0);
        tick();
        wb_valid = 1'b0;
        check_vec("raw_sb_cleared", sb_now(), 32'd0);
        check_vec("raw_release_rd_en", 32'(rf_rd_en), 32'd1);
        check_vec("raw_raddr1", 32'(rf_raddr1), 32'd5);
        tick();
        tick();
        check_vec("raw_ex_valid", 32'(ex_valid), 32'd1);
        check_vec("raw_ex_a", ex_a, 32'h55);
        check_vec("raw_ex_b_unused", ex_b, 32'd0);
        check_vec("raw_ex_rd", 32'(ex_rd), 32'd6);
        check_vec("raw_ex_imm", ex_imm, 32'h10);
        tick();
        wb_clear(4'd6);
        check_vec("raw_sb_final", sb_now(), 32'd0);

        // r0 handling with every writable register pending
        for (int r = 1; r < 16; r++) issue_one(mk(OP_LOAD, 4'(r), 4'd0, 4'd0, 16'h0), 32'(32'h200 + 4 * r));
        check_vec("r0_sb_full", sb_now(), 32'hFFFE);
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RR, 4'd0, 4'd0, 4'd0, 16'h0);
        if_pc    = 32'h300;
        tick();
        if_valid = 1'b0;
        check_vec("r0_no_stall", 32'(rf_rd_en), 32'd1);
        tick();
        tick();
        check_vec("r0_ex_valid", 32'(ex_valid), 32'd1);
        check_vec("r0_ex_a", ex_a, 32'd0);
        check_vec("r0_ex_b", ex_b, 32'd0);
        check_vec("r0_ex_we", 32'(ex_we), 32'd0);
        check_vec("r0_sb_unchanged", sb_now(), 32'hFFFE);
        tick();
        for (int r = 1; r < 16; r++) wb_clear(4'(r));
        check_vec("r0_sb_drained", sb_now(), 32'd0);

        // Backpressure: ex_ready low for 5 ISSUE cycles
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd2, 4'd1, 4'd0, 16'h7FFF);
        if_pc    = 32'h400;
        tick();
        if_valid = 1'b0;
        tick();
        tick();
        if_valid = 1'b1;
        if_instr = mk(OP_STORE, 4'd0, 4'd3, 4'd4, 16'h0008);
        if_pc    = 32'h404;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_vec("bp_ex_valid", 32'(ex_valid), 32'd1);
            check_vec("bp_ex_a", ex_a, 32'h11);
            check_vec("bp_ex_imm", ex_imm, 32'h00007FFF);
            check_vec("bp_ex_pc", ex_pc, 32'h400);
            check_vec("bp_if_ready", 32'(if_ready), 32'd0);
            tick();
        end
        ex_ready = 1'b1;
        #1;
        check_vec("bp_hs_if_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        check_vec("bp_next_state", st_now(), 32'(DEC));
        check_vec("bp_next_rd_en", 32'(rf_rd_en), 32'd1);
        check_vec("bp_next_raddr1", 32'(rf_raddr1), 32'd3);
        check_vec("bp_next_raddr2", 32'(rf_raddr2), 32'd4);
        tick();
        tick();
        check_vec("st_ex_valid", 32'(ex_valid), 32'd1);
        check_vec("st_ex_a", ex_a, 32'h33);
        check_vec("st_ex_b", ex_b, 32'h44);
        check_vec("st_ex_we", 32'(ex_we), 32'd0);
        check_vec("st_ex_pc", ex_pc, 32'h404);
        tick();
        wb_clear(4'd2);
        check_vec("bp_sb_final", sb_now(), 32'd0);

        // flush in RD
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd7, 4'd1, 4'd0, 16'h0001);
        if_pc    = 32'h500;
        tick();
        if_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_vec("flrd_state", st_now(), 32'(IDLE));
        check_vec("flrd_ex_valid", 32'(ex_valid), 32'd0);
        check_vec("flrd_sb", sb_now(), 32'd0);

        // flush in ISSUE wins over a ready handshake and clears sb[7]
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd7, 4'd1, 4'd0, 16'h0001);
        if_pc    = 32'h504;
        tick();
        if_valid = 1'b0;
        tick();
        tick();
        check_vec("fliss_sb_set", sb_now(), 32'h0080);
        flush    = 1'b1;
        if_valid = 1'b1;
        #1;
        check_vec("fliss_if_ready", 32'(if_ready), 32'd0);
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check_vec("fliss_ex_valid", 32'(ex_valid), 32'd0);
        check_vec("fliss_state", st_now(), 32'(IDLE));
        check_vec("fliss_sb", sb_now(), 32'd0);

        // same-cycle set and writeback clear of r7: set wins
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd7, 4'd1, 4'd0, 16'h0001);
        if_pc    = 32'h508;
        tick();
        if_valid = 1'b0;
        tick();
        wb_valid = 1'b1;
        wb_rd    = 4'd7;
        tick();
        wb_valid = 1'b0;
        check_vec("setwin_state", st_now(), 32'(ISSUE));
        check_vec("setwin_sb", sb_now(), 32'h0080);
        tick();
        wb_clear(4'd7);
        check_vec("setwin_sb_clr", sb_now(), 32'd0);

        // reset while holding in ISSUE with sb = 0x00F0
        issue_one(mk(OP_LOAD, 4'd4, 4'd1, 4'd0, 16'h0), 32'h600);
        issue_one(mk(OP_LOAD, 4'd5, 4'd1, 4'd0, 16'h0), 32'h604);
        issue_one(mk(OP_LOAD, 4'd6, 4'd1, 4'd0, 16'h0), 32'h608);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = mk(OP_ALU_RI, 4'd7, 4'd1, 4'd0, 16'h0002);
        if_pc    = 32'h60C;
        tick();
        if_valid = 1'b0;
        tick();
        tick();
        check_vec("mrst_pre_valid", 32'(ex_valid), 32'd1);
        check_vec("mrst_pre_sb", sb_now(), 32'h00F0);
        reset = 1'b1;
        #1;
        check_vec("mrst_if_ready", 32'(if_ready), 32'd0);
        tick();
        check_vec("mrst_ex_valid", 32'(ex_valid), 32'd0);
        check_vec("mrst_sb", sb_now(), 32'd0);
        check_vec("mrst_state", st_now(), 32'(IDLE));
        check_vec("mrst_ex_a", ex_a, 32'd0);
        check_vec("mrst_ex_we", 32'(ex_we), 32'd0);
        reset    = 1'b0;
        ex_ready = 1'b1;
        #1;
        check_vec("mrst_post_if_ready", 32'(if_ready), 32'd1);
        issue_one(mk(OP_ALU_RR, 4'd8, 4'd4, 4'd5, 16'h0), 32'h700);
        check_vec("mrst_no_residual_a", ex_a, 32'h44);
        check_vec("mrst_no_residual_b", ex_b, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Instruction decode/issue stage directly upstream of the CPU register file.
- Accepts fetched 32-bit instructions over valid/ready and decodes them.
- Tracks pending register writes in a 16-entry scoreboard and stalls on RAW hazards.
- Drives the register file read ports, captures the operands one cycle later, and presents a decoded bundle to execute over valid/ready.

Parameters:
- NREGS, 16, number of architectural registers; register 0 reads as zero and is never written.
- XLEN, 32, data and instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  sync reset, active-high
- if_valid  in  1  fetch has an instruction
- if_instr  in  32  instruction
- if_pc  in  32  instruction address
- if_ready  out  1  stage accepts the instruction this cycle
- rf_raddr1  out  5  register file read address 1, {1'b0, rs1}
- rf_raddr2  out  5  register file read address 2, {1'b0, rs2}
- rf_rd_en  out  1  read strobe; RF data is valid the cycle after
- rf_rdata1  in  32  registered read data 1
- rf_rdata2  in  32  registered read data 2
- wb_valid  in  1  writeback retiring a write
- wb_rd  in  4  destination being retired
- flush  in  1  discard the held instruction (taken branch)
- ex_valid  out  1  decoded bundle valid
- ex_ready  in  1  execute accepts the bundle
- ex_op  out  4  opcode
- ex_rd  out  4  destination register
- ex_we  out  1  instruction writes rd
- ex_a  out  32  operand A
- ex_b  out  32  operand B
- ex_imm  out  32  sign-extended imm16
- ex_pc  out  32  pc

Behaviour:
- Instruction format: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm16[15:0].
- Opcode classes:
  - ALU_RR (0x1): reads rs1 and rs2, writes rd.
  - ALU_RI (0x2) and LOAD (0x3): read rs1, write rd.
  - STORE (0x4) and BRANCH (0x5): read rs1 and rs2, no write.
  - NOP (0x0) and all other opcodes: no reads, no write.
- Writes with rd = 0 are forced ex_we = 0.
- FSM states: IDLE, DEC, RD, ISSUE.
  - IDLE: if_ready = 1. On if_valid, latch instr and pc, then go to DEC.
  - DEC: form hazard = (used rs1 != 0 and sb[rs1]) or (used rs2 != 0 and sb[rs2]).
    - If hazard, stay in DEC.
    - Otherwise pulse rf_rd_en for one cycle with the addresses valid and go to RD.
  - RD: capture rf_rdata1/2 into ex_a/ex_b. An unused or zero register yields 0. Go to ISSUE.
    - In the same cycle, set sb[rd] if the instruction writes a nonzero rd.
  - ISSUE: ex_valid = 1 and all ex_* outputs held stable until ex_valid and ex_ready.
    - On the handshake, if_ready is also asserted that cycle. If if_valid is high, go to DEC with the new instruction; else go to IDLE.
- Minimum throughput: one instruction per 3 cycles with no hazard. Latency from if acceptance to ex_valid is 2 cycles.
- Scoreboard: a 16-bit sb, reset to 0.
  - wb_valid clears sb[wb_rd]; wb_rd = 0 is ignored.
  - If a set and a clear of the same index occur in the same cycle, set wins.
  - A clear in the same cycle as DEC evaluation is visible next cycle only; no bypass.
- flush: in DEC, RD or ISSUE, return to IDLE and drop ex_valid the next cycle.
  - An sb bit already set by the flushed instruction is cleared.
  - flush has priority over the ex handshake and over if acceptance.
- Reset values: IDLE, sb = 0, if_ready = 0 during reset, and 0 for ex_valid, rf_rd_en, rf_raddr*, all ex_* data and ex_we.
- Reset mid-operation discards everything; no residual sb bits.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_NOP, OP_ALU_RR, OP_ALU_RI, OP_LOAD, OP_STORE, OP_BRANCH.
  - Field bit positions.
  - NREGS and XLEN.
- One natural sub-module: id_scoreboard, covering set/clear/flush-clear and the two hazard lookups.

Test Plan:
- Single ALU_RR r3 = r1 + r2 with sb clear, RF returning 0x11 and 0x22: rf_rd_en appears 1 cycle after acceptance, and ex_valid appears 2 cycles after with ex_a = 0x11, ex_b = 0x22, ex_rd = 3, ex_we = 1, sb[3] = 1.
- RAW hazard: LOAD r5, then ALU_RI reading r5. The second stalls in DEC until wb_valid with wb_rd = 5, issues 1 cycle later, and rf_rd_en never fires during the stall.
- r0 handling: ALU_RR rd = 0 with rs1 = 0 and rs2 = 0 while sb is all ones (forced). No stall, ex_a = ex_b = 0, ex_we = 0, sb unchanged.
- Backpressure: ex_ready held low for 5 cycles in ISSUE. ex_* stays stable, if_ready = 0 throughout, and the next instruction is accepted exactly on the handshake cycle.
- flush in RD after an instruction writing r7: next cycle is IDLE, ex_valid = 0 and sb[7] = 0. Also cover a same-cycle set of r7 with wb_valid on r7, where sb[7] must be 1.
- reset asserted in ISSUE with sb = 0x00F0: next cycle ex_valid = 0, sb = 0, state IDLE, and if_ready = 1 after reset deasserts.
